// File: rtl/q824_pkg.sv
// rtl/q824_pkg.sv - Q8.24 fixed-point shared definitions
package q824_pkg;

  localparam int          Q824_FRAC = 24;
  localparam logic [31:0] Q824_ONE  = 32'h0100_0000;

  typedef logic signed [31:0] q824_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, priority starts just after ptr
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [ID_W-1:0]  ptr,
  input  logic [N_REQ-1:0] valid,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  // Two passes replace a modulo search: indices above ptr first, then the wrap.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && valid[j] && (j > int'(ptr))) begin
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        found    = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && valid[j] && (j <= int'(ptr))) begin
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sin_taylor_q824.sv
// rtl/sin_taylor_q824.sv - combinational Q8.24 sine, Taylor series to x^7
module sin_taylor_q824
  import q824_pkg::*;
(
  input  q824_t x,
  output q824_t y
);

  // Reciprocals of 3!, 5!, 7! in Q0.24 turn the divides into multiplies.
  localparam logic signed [63:0] INV6    = 64'sd2796203;
  localparam logic signed [63:0] INV120  = 64'sd139810;
  localparam logic signed [63:0] INV5040 = 64'sd3329;

  logic signed [63:0] x64, x2, x3, x5, x7, t3, t5, t7;

  always_comb begin
    x64 = {{32{x[31]}}, x};
    x2  = (x64 * x64) >>> Q824_FRAC;
    x3  = (x2 * x64) >>> Q824_FRAC;
    x5  = (x3 * x2) >>> Q824_FRAC;
    x7  = (x5 * x2) >>> Q824_FRAC;
    t3  = (x3 * INV6) >>> Q824_FRAC;
    t5  = (x5 * INV120) >>> Q824_FRAC;
    t7  = (x7 * INV5040) >>> Q824_FRAC;
    y   = 32'(x64 - t3 + t5 - t7);
  end

endmodule

// File: rtl/sin_rr_scheduler.sv
// rtl/sin_rr_scheduler.sv - round-robin sharing of one sine evaluator across requesters
module sin_rr_scheduler
  import q824_pkg::*;
#(
  parameter int          N_REQ   = 4,
  parameter int          ID_W    = 2,
  parameter logic [31:0] MAX_ABS = Q824_ONE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_x,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_sin,
  output logic                  rsp_ovr,
  output logic                  busy
);

  localparam q824_t MAX_POS = q824_t'(MAX_ABS);
  localparam q824_t MAX_NEG = -MAX_POS;

  logic             s1_v;
  q824_t            s1_x;
  logic [ID_W-1:0]  s1_id;
  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_found;
  q824_t            gnt_x;
  q824_t            sin_y;
  logic             adv1, adv2, accept;

  assign adv2   = !rsp_valid || rsp_ready;
  assign adv1   = !s1_v || adv2;
  assign accept = adv1 && gnt_found;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .ptr   (rr_ptr),
    .valid (req_valid),
    .grant (gnt),
    .idx   (gnt_idx),
    .found (gnt_found)
  );

  assign req_ready = adv1 ? gnt : '0;

  always_comb begin
    gnt_x = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) gnt_x = q824_t'(req_x[32*i +: 32]);
    end
  end

  sin_taylor_q824 u_sin (
    .x (s1_x),
    .y (sin_y)
  );

  // Operand stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_x   <= '0;
      s1_id  <= '0;
      rr_ptr <= ID_W'(N_REQ - 1);
    end else if (accept) begin
      s1_v   <= 1'b1;
      s1_x   <= gnt_x;
      s1_id  <= gnt_idx;
      rr_ptr <= gnt_idx;
    end else if (adv1) begin
      s1_v   <= 1'b0;
    end
  end

  // Result stage; holds stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sin   <= '0;
      rsp_id    <= '0;
      rsp_ovr   <= 1'b0;
    end else if (adv2) begin
      rsp_valid <= s1_v;
      if (s1_v) begin
        rsp_sin <= sin_y;
        rsp_id  <= s1_id;
        rsp_ovr <= (s1_x > MAX_POS) || (s1_x < MAX_NEG);
      end
    end
  end

  assign busy = s1_v || rsp_valid;

endmodule

// File: tb/tb_sin_rr_scheduler.sv
// tb/tb_sin_rr_scheduler.sv - scoreboard bench for sin_rr_scheduler
module tb_sin_rr_scheduler;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_sin;
  logic                rsp_ovr;
  logic                busy;

  always #5 clk = ~clk;

  sin_rr_scheduler #(
    .N_REQ   (N_REQ),
    .ID_W    (ID_W),
    .MAX_ABS (32'h0100_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sin   (rsp_sin),
    .rsp_ovr   (rsp_ovr),
    .busy      (busy)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] x;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] pend_x [N_REQ][32];
  int          head [N_REQ] = '{default: 0};
  int          tail [N_REQ] = '{default: 0};
  logic [3:0]  acc_s;
  bit          sp_en = 1'b0;
  bit          prev_v = 1'b0;
  int          rsp_hi = 0;
  int          rsp_rise = 0;
  logic [31:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic bit ovr_model(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    return (v > 64'sd16777216) || (v < -64'sd16777216);
  endfunction

  function automatic int sin_ref(input logic [31:0] x);
    real r;
    r = $itor($signed(x)) / 16777216.0;
    return $rtoi($sin(r) * 16777216.0);
  endfunction

  task automatic enqueue(input int r, input logic [31:0] x);
    pend_x[r][tail[r] % 32] = x;
    tail[r]++;
  endtask

  task automatic expect_rsp(input int r, input logic [31:0] x);
    exp_t t;
    t.id = 2'(r);
    t.x  = x;
    sb.push_back(t);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      tick(1);
      k++;
    end
    check(name, 32'(sb.size()), 32'd0);
    tick(3);
  endtask

  // Requester model: each requester presents its queue head until accepted
  initial begin
    req_valid = '0;
    req_x     = '0;
    forever begin
      @(negedge clk);
      acc_s = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc_s[i] && head[i] < tail[i]) head[i]++;
        req_valid[i] = head[i] < tail[i];
        req_x[32*i +: 32] = req_valid[i] ? pend_x[i][head[i] % 32] : 32'h0;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d sin %h, expected no response", rsp_id, rsp_sin);
      end else begin
        int diff;
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_ovr", 32'(rsp_ovr), 32'(ovr_model(e.x)));
        if (e.x == 32'h0) begin
          check("rsp_sin_zero", rsp_sin, 32'h0);
        end else if ($signed(e.x) <= 32'sh0100_0001 && $signed(e.x) >= -32'sh0100_0001) begin
          diff = $signed(rsp_sin) - sin_ref(e.x);
          n_chk++;
          if (diff > 1000 || diff < -1000) begin
            n_fail++;
            $display("FAIL rsp_sin x=%h: got %h, expected %h +-1000", e.x, rsp_sin, sin_ref(e.x));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (sp_en) begin
      if (rsp_valid) rsp_hi++;
      if (rsp_valid && !prev_v) rsp_rise++;
    end
    prev_v = rsp_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rsp_ready = 1'b1;
    tick(2);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_sin", rsp_sin, 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_ovr", 32'(rsp_ovr), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Fairness: all four valid, grants go 0,1,2,3 repeatedly
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int r = 0; r < N_REQ; r++) begin
        logic [31:0] v;
        v = 32'h0010_0000 * 32'(4 * rnd + r + 1);
        if (r % 2 == 1) v = -v;
        enqueue(r, v);
        expect_rsp(r, v);
      end
    end
    drain("drain_fairness");

    // Single request from requester 2, two-cycle latency
    enqueue(2, 32'h0080_0000);
    expect_rsp(2, 32'h0080_0000);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(req_valid[2] && req_ready[2]) && k < 10);
    check("single_accept_seen", 32'(req_valid[2] && req_ready[2]), 32'd1);
    @(negedge clk);
    check("single_lat_1cyc", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("single_lat_2cyc", 32'(rsp_valid), 32'd1);
    tick(1);
    drain("drain_single");

    // Backpressure: rr_ptr is 2, so grant order is 3,0,1,2
    rsp_ready = 1'b0;
    for (int r = 0; r < N_REQ; r++) enqueue(r, 32'h0030_0000 * 32'(r + 1));
    expect_rsp(3, 32'h00C0_0000);
    expect_rsp(0, 32'h0030_0000);
    expect_rsp(1, 32'h0060_0000);
    expect_rsp(2, 32'h0090_0000);
    tick(4);
    check("stall_req_ready", 32'(req_ready), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    held = rsp_sin;
    tick(1);
    check("stall_rsp_sin_held", rsp_sin, held);
    check("stall_rsp_id_held", 32'(rsp_id), 32'd3);
    rsp_ready = 1'b1;
    drain("drain_backpressure");

    // Range flag boundaries, all from requester 1
    enqueue(1, 32'h0100_0000);  expect_rsp(1, 32'h0100_0000);
    enqueue(1, 32'h0100_0001);  expect_rsp(1, 32'h0100_0001);
    enqueue(1, 32'hFEFF_FFFF);  expect_rsp(1, 32'hFEFF_FFFF);
    enqueue(1, 32'h0000_0000);  expect_rsp(1, 32'h0000_0000);
    enqueue(1, 32'h8000_0000);  expect_rsp(1, 32'h8000_0000);
    drain("drain_range");

    // Sparse traffic: requester 3 every third cycle
    rsp_hi   = 0;
    rsp_rise = 0;
    sp_en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enqueue(3, 32'h0020_0000 * 32'(i + 1));
      expect_rsp(3, 32'h0020_0000 * 32'(i + 1));
      @(posedge clk);
      @(negedge clk);
      check("sparse_immediate_ready", 32'(req_ready), 32'h8);
      tick(2);
    end
    drain("drain_sparse");
    sp_en = 1'b0;
    check("sparse_valid_cycles", 32'(rsp_hi), 32'd4);
    check("sparse_valid_pulses", 32'(rsp_rise), 32'd4);

    // Asynchronous reset with both stages full
    rsp_ready = 1'b0;
    for (int r = 0; r < N_REQ; r++) enqueue(r, 32'h0040_0000);
    tick(5);
    check("prereset_busy", 32'(busy), 32'd1);
    check("prereset_rsp_valid", 32'(rsp_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    sb.delete();
    for (int r = 0; r < N_REQ; r++) head[r] = tail[r];
    tick(2);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick(1);
    for (int r = N_REQ - 1; r >= 0; r--) enqueue(r, 32'h0008_0000 * 32'(r + 1));
    for (int r = 0; r < N_REQ; r++) expect_rsp(r, 32'h0008_0000 * 32'(r + 1));
    @(posedge clk);
    @(negedge clk);
    check("post_reset_first_grant", 32'(req_ready), 32'h1);
    tick(1);
    drain("drain_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sin_rr_scheduler.md
Name: sin_rr_scheduler

Overview:
- Shares one combinational sin_taylor_q824 evaluator between N_REQ requesters in the Heston characteristic-function datapath (phase terms u·t, u·ln S).
- Round-robin arbitration with valid/ready handshakes on every requester and on the response.
- Two-stage pipeline: operand register, then result register.
- Each result carries the requester ID and an out-of-range flag.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= N_REQ.
- MAX_ABS, 32'h0100_0000, largest |x| (Q8.24, 1.0 rad) inside the evaluator's accuracy band.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_x  in  32*N_REQ  signed Q8.24 angles; requester i uses bits [32i+31:32i].
- req_ready  out  N_REQ  one-hot-or-zero accept.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_id  out  ID_W  index of the requester that produced the result.
- rsp_sin  out  32  signed Q8.24 sin(x).
- rsp_ovr  out  1  high when |x| > MAX_ABS (result still delivered).
- busy  out  1  high when either pipeline stage holds valid data.

Behaviour:
- Reset: all outputs 0; both stage valids 0; rr_ptr = N_REQ-1, so requester 0 has first priority.
- Stage S1 (operand register) holds: s1_v, s1_x, s1_id.
- Stage S2 (result register) holds: rsp_valid, rsp_sin, rsp_id, rsp_ovr.
- Advance conditions:
  - adv2 = !rsp_valid | rsp_ready.
  - adv1 = !s1_v | adv2.
- Grant (combinational):
  - Search req_valid starting at (rr_ptr+1) mod N_REQ, wrapping; the first set bit wins.
  - req_ready[g] = adv1 for the winner; all other req_ready bits are 0.
  - req_ready may depend on req_valid.
  - If no requester is valid, req_ready = 0.
- Accept (req_valid[g] & req_ready[g]):
  - S1 loads x, id = g, s1_v = 1.
  - rr_ptr <= g.
  - rr_ptr changes only on an accept.
- If adv1 holds and there is no accept, s1_v <= 0.
- S2 load when adv2 & s1_v:
  - rsp_sin <= sin_taylor_q824(s1_x); rsp_id <= s1_id.
  - rsp_ovr <= (s1_x > MAX_ABS) | (s1_x < -MAX_ABS), signed compare.
  - x = 32'h8000_0000 counts as out of range.
- If adv2 & !s1_v, rsp_valid <= 0.
- Latency and throughput:
  - Accept to rsp_valid is exactly 2 cycles when unstalled.
  - One result per cycle sustained.
- Backpressure:
  - While rsp_ready is low with rsp_valid high, S2 holds stable (sin, id, ovr unchanged).
  - S1 holds if full; req_ready falls to 0 once both stages are full.
  - No result is lost or duplicated.
- Simultaneous rsp handshake and new accept in the same cycle: both take effect; full throughput is kept.
- A requester that drops req_valid before being granted loses nothing; there is no state per requester.
- Asynchronous reset mid-operation clears both stages immediately; in-flight results are discarded; rr_ptr returns to N_REQ-1.
- busy = s1_v | rsp_valid.

Decomposition:
- Shared package q824_pkg:
  - Q824_FRAC = 24.
  - Q824_ONE = 32'h0100_0000.
  - Typedef q824_t (signed 32-bit).
- Sub-module rr_arbiter (N_REQ, ptr in, valid in → one-hot grant plus encoded index), reusable for other shared math units (exp, ln).
- sin_taylor_q824 is instantiated once on s1_x.

Test Plan:
- Single request: requester 2 sends x = 32'h0080_0000 (0.5 rad) with rsp_ready = 1 → 2 cycles later rsp_valid = 1, rsp_id = 2, rsp_sin within ±1000 LSB of 32'h007A_BBA1, rsp_ovr = 0.
- Fairness: all 4 requesters valid continuously, each holding a distinct x → grants in order 0,1,2,3,0,1,…, and rsp_id follows the same sequence.
- Backpressure:
  - Setup: 4 requests back-to-back with rsp_ready low for 5 cycles.
  - During the stall: req_ready = 0 once both stages are full, and rsp_sin is held stable.
  - After release: all 4 results arrive in grant order with no loss or duplication.
- Range flag:
  - x = 32'h0100_0000 → rsp_ovr = 0.
  - x = 32'h0100_0001 → rsp_ovr = 1.
  - x = 32'hFEFF_FFFF (just below -1.0) → rsp_ovr = 1.
  - x = 0 → rsp_sin = 0.
- Reset mid-flight: assert rst_n = 0 asynchronously with both stages full → rsp_valid and busy drop to 0 with no clock edge; after release the next grant goes to requester 0.
- Sparse traffic: only requester 3 valid, every third cycle → each request is accepted immediately, rsp_id = 3 each time, and rsp_valid pulses for exactly 1 cycle per request.
